// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer
// (head + skid slot), flush-to-bubble, zeroed control on bubbles and a
// saturating stall counter for performance debug.
module pipe_stage_skid #(
    parameter int DATA_W = 112,
    parameter int CTRL_W = 26,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              stall_cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        occupancy
);

    logic              vld_p1;
    logic [DATA_W-1:0] head_data_p1;
    logic [CTRL_W-1:0] head_ctrl_p1;
    logic              skid_vld_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic [CTRL_W-1:0] skid_ctrl_p1;
    logic              ready_q;
    logic [CNT_W-1:0]  stall_q;
    logic              in_fire;
    logic              out_fire;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + 1'b1;
    endfunction

    assign in_fire   = in_valid & ready_q;
    assign out_fire  = vld_p1 & out_ready;

    assign in_ready  = ready_q;
    assign out_valid = vld_p1;
    assign out_data  = head_data_p1;
    // Bubbles must never carry live control bits downstream.
    assign out_ctrl  = vld_p1 ? head_ctrl_p1 : '0;
    assign occupancy = {vld_p1 & skid_vld_p1, vld_p1 ^ skid_vld_p1};
    assign stall_cnt = stall_q;

    // Input -> head/skid slot boundary; flush kills both slots and the same-cycle input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p1       <= 1'b0;
            skid_vld_p1  <= 1'b0;
            ready_q      <= 1'b1;
            head_data_p1 <= '0;
            head_ctrl_p1 <= '0;
            skid_data_p1 <= '0;
            skid_ctrl_p1 <= '0;
        end else if (flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            ready_q     <= 1'b1;
        end else if (!vld_p1) begin
            if (in_fire) begin
                vld_p1       <= 1'b1;
                head_data_p1 <= in_data;
                head_ctrl_p1 <= in_ctrl;
            end
        end else if (!skid_vld_p1) begin
            if (in_fire && out_fire) begin
                head_data_p1 <= in_data;
                head_ctrl_p1 <= in_ctrl;
            end else if (in_fire) begin
                skid_vld_p1  <= 1'b1;
                skid_data_p1 <= in_data;
                skid_ctrl_p1 <= in_ctrl;
                ready_q      <= 1'b0;
            end else if (out_fire) begin
                vld_p1 <= 1'b0;
            end
        end else begin
            // Full: in_ready is low, so only a drain can happen.
            if (out_fire) begin
                head_data_p1 <= skid_data_p1;
                head_ctrl_p1 <= skid_ctrl_p1;
                skid_vld_p1  <= 1'b0;
                ready_q      <= 1'b1;
            end
        end
    end

    // Stall counter: counts cycles a live head is refused; clear wins, flush ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (stall_cnt_clr) begin
            stall_q <= '0;
        end else if (vld_p1 && !out_ready) begin
            stall_q <= sat_inc(stall_q);
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset/bubble, streaming, skid fill,
// flush when full, counter saturation (CNT_W=4) and mid-operation reset.
module tb_pipe_stage_skid;

    localparam int DATA_W = 112;
    localparam int CTRL_W = 26;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic              flush;
    logic              stall_cnt_clr;
    logic [CNT_W-1:0]  stall_cnt;
    logic [1:0]        occupancy;

    int vectors = 0;
    int errs    = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_ctrl       (in_ctrl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .flush         (flush),
        .stall_cnt_clr (stall_cnt_clr),
        .stall_cnt     (stall_cnt),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] dpat(input logic [CTRL_W-1:0] c);
        logic [7:0] b;
        b = c[7:0];
        return {14{b}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_ctrl  = c;
        in_data  = dpat(c);
    endtask

    initial begin
        // Reset with junk offered upstream
        rst = 1'b0; flush = 1'b0; stall_cnt_clr = 1'b0; out_ready = 1'b0;
        drive(1'b1, '1);
        step(); step();
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out_ctrl",  128'(out_ctrl),  128'd0);
        chk("rst_out_data",  128'(out_data),  128'd0);
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_occ",       128'(occupancy), 128'd0);
        chk("rst_stall",     128'(stall_cnt), 128'd0);

        // Streaming 1..4 at full rate
        rst = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, CTRL_W'(i));
            step();
            chk("stream_ctrl",  128'(out_ctrl),  128'(i));
            chk("stream_data",  128'(out_data),  128'(dpat(CTRL_W'(i))));
            chk("stream_vld",   128'(out_valid), 128'd1);
            chk("stream_ready", 128'(in_ready),  128'd1);
            chk("stream_occ",   128'(occupancy), 128'd1);
        end
        drive(1'b0, '0);
        step();
        chk("stream_drain_vld",  128'(out_valid), 128'd0);
        chk("stream_drain_ctrl", 128'(out_ctrl),  128'd0);
        chk("stream_drain_occ",  128'(occupancy), 128'd0);
        chk("stream_stall",      128'(stall_cnt), 128'd0);

        // Skid fill: A then B with downstream stalled
        out_ready = 1'b0;
        drive(1'b1, 26'h00A);
        step();
        chk("skid_a_occ",   128'(occupancy), 128'd1);
        chk("skid_a_ctrl",  128'(out_ctrl),  128'h00A);
        chk("skid_a_stall", 128'(stall_cnt), 128'd0);
        drive(1'b1, 26'h00B);
        step();
        chk("skid_b_occ",   128'(occupancy), 128'd2);
        chk("skid_b_ready", 128'(in_ready),  128'd0);
        chk("skid_b_ctrl",  128'(out_ctrl),  128'h00A);
        chk("skid_b_stall", 128'(stall_cnt), 128'd1);
        drive(1'b0, '0);
        step();
        chk("skid_hold_occ",   128'(occupancy), 128'd2);
        chk("skid_hold_stall", 128'(stall_cnt), 128'd2);
        out_ready = 1'b1;
        step();
        chk("skid_outb_ctrl",  128'(out_ctrl),  128'h00B);
        chk("skid_outb_data",  128'(out_data),  128'(dpat(26'h00B)));
        chk("skid_outb_ready", 128'(in_ready),  128'd1);
        chk("skid_outb_occ",   128'(occupancy), 128'd1);
        chk("skid_outb_stall", 128'(stall_cnt), 128'd2);
        step();
        chk("skid_empty_vld", 128'(out_valid), 128'd0);
        chk("skid_empty_occ", 128'(occupancy), 128'd0);

        // Flush when full with C offered the same cycle
        out_ready = 1'b0;
        drive(1'b1, 26'h011); step();
        drive(1'b1, 26'h022); step();
        chk("fl_full_occ", 128'(occupancy), 128'd2);
        drive(1'b1, 26'h033); flush = 1'b1;
        step();
        flush = 1'b0; drive(1'b0, '0);
        chk("fl_vld",   128'(out_valid), 128'd0);
        chk("fl_ctrl",  128'(out_ctrl),  128'd0);
        chk("fl_occ",   128'(occupancy), 128'd0);
        chk("fl_ready", 128'(in_ready),  128'd1);
        chk("fl_stall", 128'(stall_cnt), 128'd4);
        out_ready = 1'b1;
        step();
        chk("fl_noc_vld",  128'(out_valid), 128'd0);
        chk("fl_noc_ctrl", 128'(out_ctrl),  128'd0);

        // Counter saturation and clear-over-increment
        stall_cnt_clr = 1'b1; step(); stall_cnt_clr = 1'b0;
        chk("sat_clr0", 128'(stall_cnt), 128'd0);
        out_ready = 1'b0;
        drive(1'b1, 26'h044); step();
        drive(1'b0, '0);
        for (int i = 0; i < 20; i++) step();
        chk("sat_15",  128'(stall_cnt), 128'd15);
        chk("sat_vld", 128'(out_valid), 128'd1);
        stall_cnt_clr = 1'b1; step(); stall_cnt_clr = 1'b0;
        chk("sat_clr", 128'(stall_cnt), 128'd0);
        step();
        chk("sat_after_clr", 128'(stall_cnt), 128'd1);

        // Mid-operation reset while full
        drive(1'b1, 26'h055); step();
        chk("mr_full_occ", 128'(occupancy), 128'd2);
        drive(1'b0, '0); rst = 1'b0;
        step();
        chk("mr_vld",   128'(out_valid), 128'd0);
        chk("mr_ctrl",  128'(out_ctrl),  128'd0);
        chk("mr_data",  128'(out_data),  128'd0);
        chk("mr_ready", 128'(in_ready),  128'd1);
        chk("mr_occ",   128'(occupancy), 128'd0);
        chk("mr_stall", 128'(stall_cnt), 128'd0);
        rst = 1'b1; out_ready = 1'b1;
        drive(1'b1, 26'h066);
        step();
        drive(1'b0, '0);
        chk("mr_push_vld",  128'(out_valid), 128'd1);
        chk("mr_push_ctrl", 128'(out_ctrl),  128'h066);
        chk("mr_push_data", 128'(out_data),  128'(dpat(26'h066)));
        step();
        chk("mr_end_vld", 128'(out_valid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed ID/EX-style pipeline registers. It carries one flattened data bundle and one control bundle between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with registered backpressure.
- Flush inserts bubbles; control bits are forced to zero on every bubble.
- A saturating stall counter supports performance debug.
- Instanced between IF/ID, ID/EX, EX/MEM and MEM/WB with different widths.

Parameters:
- DATA_W, 112: width of in_data/out_data (default is seven 16-bit lanes, concatenated).
- CTRL_W, 26: width of in_ctrl/out_ctrl (EX/M/WB control plus the 3-bit destination register number).
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset: sampled on the rising edge; 0 = reset.
- in_valid  in  1  upstream offers in_data/in_ctrl.
- in_ready  out  1  stage can accept; driven directly from a flop.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  out_data/out_ctrl hold a live instruction.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head-slot data.
- out_ctrl  out  CTRL_W  head-slot control; all-zero whenever out_valid=0.
- flush  in  1  kill all held entries plus any same-cycle input.
- stall_cnt_clr  in  1  clear the stall counter.
- stall_cnt  out  CNT_W  count of cycles with out_valid=1 and out_ready=0.
- occupancy  out  2  number of held entries (0, 1 or 2).

Behaviour:
- Storage: head slot H (drives the outputs) and skid slot S. Each slot stores data, ctrl and a valid bit.
- Handshake terms: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready is registered and equals (next occupancy != 2). It never depends combinationally on out_ready.
- Reset (rst=0 at an edge) produces:
  - H and S invalid; occupancy=0.
  - out_valid=0; out_data=0; out_ctrl=0.
  - in_ready=1; stall_cnt=0.
- State EMPTY (occ 0):
  - in_fire -> H<=input; go to ONE.
- State ONE (occ 1):
  - in_fire & out_fire -> H<=input; stay in ONE.
  - in_fire & !out_fire -> S<=input; go to FULL; in_ready<=0.
  - !in_fire & out_fire -> go to EMPTY.
  - neither -> hold.
- State FULL (occ 2):
  - in_ready=0, so in_fire is impossible.
  - out_fire -> H<=S, S invalid; go to ONE; in_ready<=1.
- Latency and throughput:
  - Input accepted at edge N appears on the outputs after edge N (one-cycle latency).
  - Sustained throughput is 1 per cycle while out_ready=1.
  - Order is strictly FIFO; no entry is dropped or duplicated except by flush.
- Flush (highest priority below reset):
  - At the edge: H and S invalid; occupancy=0; in_ready<=1.
  - A same-cycle in_fire is discarded.
  - out_fire in the flush cycle still counts as consumed by downstream.
- Bubble rule: out_ctrl=0 whenever H is invalid, so RegWriteEN, MemWr, MemEn and dump cannot fire on a bubble. out_data holds its last value (don't-care).
- Stall counter:
  - Increments when out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; no wrap-around.
  - stall_cnt_clr beats increment; after a clear, the value is 0.
  - Flush does not affect it.
- Occupancy after any edge equals the number of valid slots; it never exceeds 2.

Test Plan:
- Reset/bubble: hold rst=0 two cycles with in_valid=1, in_ctrl=all-ones -> out_valid=0, out_ctrl=0, in_ready=1, occupancy=0, stall_cnt=0.
- Streaming: out_ready=1; push ctrl values 1,2,3,4 on consecutive cycles -> out_ctrl shows 1,2,3,4 one cycle later on consecutive cycles; in_ready stays 1.
- Skid fill: push A,B with out_ready=0 -> occupancy=2, in_ready=0, stall_cnt increments each cycle; raise out_ready -> A then B out in order, in_ready returns to 1 after A leaves.
- Flush when full: occupancy=2 with in_valid=1 C and flush=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0; C never appears on the outputs.
- Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15; pulse stall_cnt_clr with the stall ongoing -> stall_cnt=0, then 1 on the next cycle.
- Mid-op reset: occupancy=2, rst=0 for one edge -> all outputs at reset values; the first push after rst=1 appears one cycle later.
